// File: rtl/fifo_rd_axis_if.sv
// Bundle of the FIFO read port and the AXI-Stream master side of fifo_rd_axis.
// master = the fifo_rd_axis stage, slave = the FIFO plus downstream consumer.
`ifndef AXI_ST_DATA_W
`define AXI_ST_DATA_W 64
`endif

interface fifo_rd_axis_if #(
    parameter int DATA_WIDTH = `AXI_ST_DATA_W
);
    logic                  fifo_rd;
    logic [DATA_WIDTH-1:0] fifo_q;
    logic                  fifo_mty;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tlast;
    logic [1:0]            buf_count;

    modport master (
        output fifo_rd, m_axis_tvalid, m_axis_tdata, m_axis_tlast, buf_count,
        input  fifo_q, fifo_mty, m_axis_tready
    );

    modport slave (
        input  fifo_rd, m_axis_tvalid, m_axis_tdata, m_axis_tlast, buf_count,
        output fifo_q, fifo_mty, m_axis_tready
    );
endinterface

// File: rtl/fifo_rd_axis.sv
// FIFO read side to AXI-Stream master with a credit-controlled skid buffer.
// Optional TLAST generation every PKT_LEN beats when FIFO_RD_AXIS_TLAST_EN is defined.
`ifndef AXI_ST_DATA_W
`define AXI_ST_DATA_W 64
`endif

module fifo_rd_axis #(
    parameter int DATA_WIDTH = `AXI_ST_DATA_W,
    parameter int RD_LATENCY = 1,
    parameter int PKT_LEN    = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    fifo_rd_axis_if.master bus
);
    localparam int DEPTH = RD_LATENCY + 1;

    if (RD_LATENCY < 1 || RD_LATENCY > 2 || PKT_LEN < 1) begin : g_param_chk
        $error("fifo_rd_axis: RD_LATENCY must be 1 or 2 and PKT_LEN >= 1");
    end

    // Storage is indexed by 2-bit pointers; only entries 0..DEPTH-1 are ever used.
    logic [DATA_WIDTH-1:0] mem_q [4];
    logic [1:0]            wr_ptr_q, wr_ptr_d;
    logic [1:0]            rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;
    logic                  valid_q, valid_d;
    logic [RD_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
    logic [2:0]            inflight;
    logic                  push, pop, rd;

    function automatic logic [1:0] ptr_inc(logic [1:0] p);
        return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + 3'(vld_pipe_q[i]);
    end

    assign pop  = valid_q & bus.m_axis_tready;
    assign push = vld_pipe_q[RD_LATENCY-1];
    // Only request a word if a slot is guaranteed for it once every in-flight read lands.
    assign rd   = rst_n & ~bus.fifo_mty & ((3'(count_q) + inflight - 3'(pop)) < 3'(DEPTH));

    always_comb begin
        vld_pipe_d    = vld_pipe_q << 1;
        vld_pipe_d[0] = rd;
        wr_ptr_d      = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d      = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d       = count_q + 2'(push) - 2'(pop);
        valid_d       = (count_d != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            vld_pipe_q <= '0;
            for (int i = 0; i < 4; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            vld_pipe_q <= vld_pipe_d;
            if (push) mem_q[wr_ptr_q] <= bus.fifo_q;
        end
    end

    // The head slot is only rewritten on a full buffer together with a pop, so tdata holds under stall.
    assign bus.fifo_rd       = rd;
    assign bus.m_axis_tvalid = valid_q;
    assign bus.m_axis_tdata  = mem_q[rd_ptr_q];
    assign bus.buf_count     = count_q;

`ifdef FIFO_RD_AXIS_TLAST_EN
    localparam int BW = $clog2(PKT_LEN) + 1;

    logic [BW-1:0] beat_q, beat_d;
    logic          last_beat;

    assign last_beat = (beat_q == BW'(PKT_LEN - 1));

    always_comb begin
        beat_d = beat_q;
        if (pop) beat_d = last_beat ? '0 : beat_q + BW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) beat_q <= '0;
        else        beat_q <= beat_d;
    end

    assign bus.m_axis_tlast = valid_q & last_beat;
`else
    assign bus.m_axis_tlast = 1'b0;
`endif

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && count_q == 2'(DEPTH) && !pop))
        else $error("fifo_rd_axis: push into full skid buffer");

endmodule

// File: tb/tb_fifo_rd_axis.sv
// Drives one fifo_rd_axis per legal RD_LATENCY from a shared word list and
// scores each output stream against the FIFO contents it drained.
`timescale 1ns/1ps
module tb_fifo_rd_axis;
    localparam int W    = 8;
    localparam int NDUT = 2;
    localparam int MEMD = 256;

    logic clk = 1'b0;
    logic rst_n;
    logic tready;
    always #5 clk = ~clk;

    logic [W-1:0] mem [MEMD];
    int           wr_idx;
    int           rd_idx [NDUT] = '{0, 0};
    logic [W-1:0] qp [NDUT][2];

    logic [NDUT-1:0]        rd, mty, tvalid, tlast;
    logic [NDUT-1:0][1:0]   cnt;
    logic [NDUT-1:0][W-1:0] tdata, fq;

    logic [W-1:0] got     [NDUT][$];
    logic         gotlast [NDUT][$];
    int           pop_cyc [NDUT][$];
    int           rd_cyc  [NDUT][$];
    bit           underflow [NDUT];
    bit           unstable  [NDUT];
    bit           hold      [NDUT];
    logic [W-1:0] hold_d    [NDUT];
    logic         hold_l    [NDUT];
    int           cyc = 0;
    int           checks, errors;

    for (genvar k = 0; k < NDUT; k++) begin : g_dut
        fifo_rd_axis_if #(.DATA_WIDTH(W)) bus ();
        fifo_rd_axis #(.DATA_WIDTH(W), .RD_LATENCY(k + 1), .PKT_LEN(4)) u_dut (
            .clk(clk), .rst_n(rst_n), .bus(bus)
        );
        assign bus.fifo_q        = fq[k];
        assign bus.fifo_mty      = mty[k];
        assign bus.m_axis_tready = tready;
        assign rd[k]             = bus.fifo_rd;
        assign tvalid[k]         = bus.m_axis_tvalid;
        assign tdata[k]          = bus.m_axis_tdata;
        assign tlast[k]          = bus.m_axis_tlast;
        assign cnt[k]            = bus.buf_count;
        assign mty[k]            = (rd_idx[k] == wr_idx);
        assign fq[k]             = qp[k][k];   // data valid k+1 cycles after the read
    end

    // FIFO model: a read consumes the next word; q shows garbage when no read is landing.
    always @(posedge clk) begin
        for (int k = 0; k < NDUT; k++) begin
            qp[k][1] <= qp[k][0];
            if (rd[k]) begin
                qp[k][0]  <= mem[rd_idx[k]];
                rd_idx[k] <= rd_idx[k] + 1;
            end else begin
                qp[k][0] <= W'($urandom);
            end
        end
    end

    // Mid-cycle monitor: reads, transfers and AXI stability.
    always @(negedge clk) begin
        for (int k = 0; k < NDUT; k++) begin
            if (rd[k]) begin
                rd_cyc[k].push_back(cyc);
                if (mty[k]) underflow[k] = 1'b1;
            end
            if (rst_n && hold[k] && !(tvalid[k] && tdata[k] === hold_d[k] && tlast[k] === hold_l[k]))
                unstable[k] = 1'b1;
            if (rst_n && tvalid[k] && tready) begin
                got[k].push_back(tdata[k]);
                gotlast[k].push_back(tlast[k]);
                pop_cyc[k].push_back(cyc);
            end
            hold[k]   = rst_n && tvalid[k] && !tready;
            hold_d[k] = tdata[k];
            hold_l[k] = tlast[k];
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string tag, int k, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic load(logic [W-1:0] v);
        mem[wr_idx] = v;
        wr_idx++;
    endtask

    task automatic drain(string tag, int maxc);
        int idle = 0;
        int n = 0;
        tready = 1'b1;
        while (idle < 4 && n < maxc) begin
            tick();
            n++;
            if (rd_idx[0] == wr_idx && rd_idx[1] == wr_idx && tvalid == '0 && rd == '0) idle++;
            else idle = 0;
        end
        check({tag, "_drain_timeout"}, 0, 32'(idle >= 4), 32'd1);
    endtask

    task automatic check_stream(string tag, int k, int gs, int ms, int n);
        check({tag, "_count"}, k, 32'(got[k].size() - gs), 32'(n));
        for (int i = 0; i < n && gs + i < got[k].size(); i++)
            check({tag, "_data"}, k, 32'(got[k][gs+i]), 32'(mem[ms+i]));
        check({tag, "_underflow"}, k, 32'(underflow[k]), 32'd0);
        check({tag, "_unstable"}, k, 32'(unstable[k]), 32'd0);
    endtask

    task automatic check_gapless(string tag, int k, int gs, int n);
        for (int i = 1; i < n && gs + i < pop_cyc[k].size(); i++)
            check({tag, "_gap"}, k, 32'(pop_cyc[k][gs+i] - pop_cyc[k][gs+i-1]), 32'd1);
    endtask

    initial begin
        int gs [NDUT];
        int ms [NDUT];
        int rs [NDUT];
        int left;
        logic exp_last;

        checks = 0;
        errors = 0;
        wr_idx = 0;
        rst_n  = 1'b0;
        tready = 1'b1;

        // Reset held 3 cycles with a non-empty FIFO
        for (int v = 1; v <= 8; v++) load(W'(v));
        repeat (3) begin
            tick();
            for (int k = 0; k < NDUT; k++) begin
                check("rst_rd", k, 32'(rd[k]), 32'd0);
                check("rst_tvalid", k, 32'(tvalid[k]), 32'd0);
                check("rst_tdata", k, 32'(tdata[k]), 32'd0);
                check("rst_cnt", k, 32'(cnt[k]), 32'd0);
                check("rst_tlast", k, 32'(tlast[k]), 32'd0);
            end
        end

        // Streaming 0x01..0x08 with tready high
        for (int k = 0; k < NDUT; k++) begin
            gs[k] = got[k].size(); ms[k] = rd_idx[k]; rs[k] = rd_cyc[k].size();
        end
        rst_n = 1'b1;
        drain("stream", 60);
        for (int k = 0; k < NDUT; k++) begin
            check_stream("stream", k, gs[k], ms[k], 8);
            if (rd_cyc[k].size() > rs[k] && pop_cyc[k].size() > gs[k])
                check("stream_first_lat", k, 32'(pop_cyc[k][gs[k]] - rd_cyc[k][rs[k]]), 32'(k + 2));
            check_gapless("stream", k, gs[k], 8);
        end

        // Backpressure: tready low for 10 cycles with plenty of words queued
        tready = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            gs[k] = got[k].size(); ms[k] = rd_idx[k]; rs[k] = rd_cyc[k].size();
        end
        for (int i = 0; i < 16; i++) load(W'($urandom));
        repeat (10) tick();
        for (int k = 0; k < NDUT; k++) begin
            check("bp_reads", k, 32'(rd_cyc[k].size() - rs[k]), 32'(k + 2));
            check("bp_cnt", k, 32'(cnt[k]), 32'(k + 2));
            check("bp_tvalid", k, 32'(tvalid[k]), 32'd1);
            check("bp_tdata", k, 32'(tdata[k]), 32'(mem[ms[k]]));
        end
        drain("bp", 80);
        for (int k = 0; k < NDUT; k++) begin
            check_stream("bp", k, gs[k], ms[k], 16);
            check_gapless("bp", k, gs[k], 16);
        end

        // FIFO runs dry after 3 words while tready toggles
        for (int k = 0; k < NDUT; k++) begin gs[k] = got[k].size(); ms[k] = rd_idx[k]; end
        for (int i = 0; i < 3; i++) load(W'($urandom));
        tready = 1'b0;
        repeat (20) begin
            tready = ~tready;
            tick();
        end
        drain("empty", 40);
        for (int k = 0; k < NDUT; k++) check_stream("empty", k, gs[k], ms[k], 3);

        // Reset while two words are buffered
        tready = 1'b0;
        for (int k = 0; k < NDUT; k++) rs[k] = rd_idx[k];
        for (int i = 0; i < 10; i++) load(W'($urandom));
        for (int i = 0; i < 20 && cnt[1] != 2'd2; i++) tick();
        check("rstmid_cnt_pre", 1, 32'(cnt[1]), 32'd2);
        check("rstmid_cnt_pre", 0, 32'(cnt[0]), 32'd2);
        rst_n = 1'b0;
        tick();
        for (int k = 0; k < NDUT; k++) begin
            check("rstmid_tvalid", k, 32'(tvalid[k]), 32'd0);
            check("rstmid_cnt", k, 32'(cnt[k]), 32'd0);
            check("rstmid_reads", k, 32'(rd_idx[k] - rs[k]), 32'(k + 2));
            gs[k] = got[k].size(); ms[k] = rd_idx[k];
        end
        rst_n = 1'b1;
        drain("rstmid", 60);
        for (int k = 0; k < NDUT; k++) check_stream("rstmid", k, gs[k], ms[k], wr_idx - ms[k]);

        // Random trickle loading with random backpressure
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < NDUT; k++) begin gs[k] = got[k].size(); ms[k] = rd_idx[k]; end
            left = $urandom_range(4, 16);
            for (int c = 0; c < 300 && left > 0; c++) begin
                tready = ($urandom_range(0, 9) < 7);
                if ($urandom_range(0, 2) == 0) begin
                    load(W'($urandom));
                    left--;
                end
                tick();
            end
            drain("soak", 60);
            for (int k = 0; k < NDUT; k++) check_stream("soak", k, gs[k], ms[k], wr_idx - ms[k]);
        end

        // Packet framing over 8 beats (PKT_LEN=4) under random tready
        rst_n = 1'b0;
        repeat (2) tick();
        for (int k = 0; k < NDUT; k++) check("tlast_rst", k, 32'(tlast[k]), 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < NDUT; k++) begin gs[k] = got[k].size(); ms[k] = rd_idx[k]; end
        for (int i = 0; i < 8; i++) load(W'($urandom));
        repeat (30) begin
            tready = $urandom_range(0, 1) == 1;
            tick();
        end
        drain("tlast", 60);
        for (int k = 0; k < NDUT; k++) begin
            check_stream("tlast", k, gs[k], ms[k], 8);
            for (int i = 0; i < 8 && gs[k] + i < gotlast[k].size(); i++) begin
`ifdef FIFO_RD_AXIS_TLAST_EN
                exp_last = ((i % 4) == 3);
`else
                exp_last = 1'b0;
`endif
                check("tlast_beat", k, 32'(gotlast[k][gs[k]+i]), 32'(exp_last));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
